// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: command codes, FSM states, status bits.
package spi_pkg;

  localparam logic [1:0] CMD_XFER  = 2'd0;
  localparam logic [1:0] CMD_CS_LO = 2'd1;
  localparam logic [1:0] CMD_CS_HI = 2'd2;
  localparam logic [1:0] CMD_WAIT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_TIMEOUT = 1;

  // Byte clocked out while polling, and the "no answer yet" value on MISO.
  localparam logic [7:0] IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 byte engine: SCLK divider plus 8-bit TX/RX shift registers.
module spi_shifter #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic [7:0] i_data,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic [7:0] o_rx,
  output logic       o_done_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             r_active;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic             r_sclk;
  logic             r_mosi;
  logic [7:0]       r_sh;
  logic [7:0]       r_rx;
  logic             w_tick;

  assign w_tick   = r_active && (r_div == DIV_W'(CLK_DIV - 1));
  // Last falling edge: the received byte is already complete.
  assign o_done_c = w_tick && r_sclk && (r_bit == 3'd7);
  assign o_sclk   = r_sclk;
  assign o_mosi   = r_mosi;
  assign o_rx     = r_rx;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_active <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b1;
      r_sh     <= '0;
      r_rx     <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_div    <= '0;
      r_bit    <= '0;
      r_sclk   <= 1'b0;
      r_sh     <= i_data;
      r_mosi   <= i_data[7];
    end else if (r_active) begin
      if (w_tick) begin
        r_div <= '0;
        if (!r_sclk) begin
          r_sclk <= 1'b1;
          r_rx   <= {r_rx[6:0], i_miso};
        end else begin
          r_sclk <= 1'b0;
          if (r_bit == 3'd7) begin
            r_active <= 1'b0;
            r_mosi   <= 1'b1;
          end else begin
            r_bit  <= r_bit + 3'd1;
            r_sh   <= {r_sh[6:0], 1'b1};
            r_mosi <= r_sh[6];
          end
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi.sv
// SPI master command engine: trigger synchronizer, command FSM and chip select.
module spi
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned WAIT_LIMIT = 256
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       spi_cs,
  output logic       spi_sclk,
  input  logic       spi_miso,
  output logic       spi_mosi,
  input  logic       spi_sent,
  input  logic [1:0] spi_cmd,
  output logic [7:0] spi_din,
  input  logic [7:0] spi_out,
  output logic [1:0] spi_st
);

  localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync_d;
  logic [1:0]       r_cmd;
  logic [7:0]       r_tx;
  logic             r_cs;
  logic [7:0]       r_din;
  logic             r_busy;
  logic             r_timeout;
  logic             r_start;
  logic [CNT_W-1:0] r_count;

  logic       w_trig;
  logic       w_done;
  logic [7:0] w_rx;
  logic [7:0] w_tx_byte;
  logic       w_last_byte;

  assign w_trig      = r_sync2 && !r_sync_d;
  assign w_tx_byte   = (r_cmd == CMD_WAIT) ? IDLE_BYTE : r_tx;
  assign w_last_byte = (r_count == CNT_W'(WAIT_LIMIT - 1));

  assign spi_cs              = r_cs;
  assign spi_din             = r_din;
  assign spi_st[ST_BUSY]     = r_busy;
  assign spi_st[ST_TIMEOUT]  = r_timeout;

  spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_start  (r_start),
    .i_data   (w_tx_byte),
    .i_miso   (spi_miso),
    .o_sclk   (spi_sclk),
    .o_mosi   (spi_mosi),
    .o_rx     (w_rx),
    .o_done_c (w_done)
  );

  // Synchronizer flops reset to the live input so a held-high trigger is not an edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1   <= spi_sent;
      r_sync2   <= spi_sent;
      r_sync_d  <= spi_sent;
      r_state   <= S_IDLE;
      r_cmd     <= CMD_XFER;
      r_tx      <= '0;
      r_cs      <= 1'b1;
      r_din     <= IDLE_BYTE;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_start   <= 1'b0;
      r_count   <= '0;
    end else begin
      r_sync1  <= spi_sent;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      r_start  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_cmd     <= spi_cmd;
            r_tx      <= spi_out;
            r_busy    <= 1'b1;
            r_timeout <= 1'b0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_count <= '0;
          if (r_cmd == CMD_XFER || r_cmd == CMD_WAIT) begin
            r_start <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_cs    <= (r_cmd == CMD_CS_HI);
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (w_done) begin
            r_din <= w_rx;
            // Keep polling while the slave still answers 0xFF and budget remains.
            if (r_cmd == CMD_WAIT && w_rx == IDLE_BYTE && !w_last_byte) begin
              r_count <= r_count + CNT_W'(1);
              r_start <= 1'b1;
            end else begin
              r_busy    <= 1'b0;
              r_timeout <= (r_cmd == CMD_WAIT) && (w_rx == IDLE_BYTE);
              r_state   <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi.sv
// Self-checking bench for the SPI master: randomized traffic against a byte-level slave model.
module tb_spi;
  import spi_pkg::*;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned WAIT_LIMIT = 256;

  logic       clock;
  logic       reset_n;
  logic       spi_cs;
  logic       spi_sclk;
  logic       spi_miso;
  logic       spi_mosi;
  logic       spi_sent;
  logic [1:0] spi_cmd;
  logic [7:0] spi_din;
  logic [7:0] spi_out;
  logic [1:0] spi_st;

  int checks;
  int errors;

  int   pulses;
  logic mosi_q[$];
  int   cyc;
  int   hi_cnt;
  int   first_hi;
  int   last_hi;

  logic [7:0] slv_cur;
  logic [7:0] slv_q[$];
  int         slv_bit;

  logic [7:0] resp_tab[16];
  int         resp_len;

  spi #(.CLK_DIV(CLK_DIV), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .spi_cs   (spi_cs),
    .spi_sclk (spi_sclk),
    .spi_miso (spi_miso),
    .spi_mosi (spi_mosi),
    .spi_sent (spi_sent),
    .spi_cmd  (spi_cmd),
    .spi_din  (spi_din),
    .spi_out  (spi_out),
    .spi_st   (spi_st)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Bus monitor: MOSI as seen by a mode-0 slave, plus SCLK high-time statistics.
  always @(posedge spi_sclk) begin
    pulses++;
    mosi_q.push_back(spi_mosi);
  end

  always @(negedge clock) begin
    cyc++;
    if (spi_sclk) begin
      if (first_hi < 0) first_hi = cyc;
      last_hi = cyc;
      hi_cnt++;
    end
  end

  // Mode-0 slave: presents the next bit after each falling SCLK edge.
  always @(negedge spi_sclk) begin
    if (slv_bit == 7) begin
      slv_bit = 0;
      slv_cur = (slv_q.size() > 0) ? slv_q.pop_front() : 8'hFF;
    end else begin
      slv_bit++;
    end
  end

  assign spi_miso = slv_cur[3'(7 - slv_bit)];

  task automatic clear_mon();
    pulses = 0;
    mosi_q.delete();
    hi_cnt = 0;
    first_hi = -1;
    last_hi = -1;
  endtask

  task automatic slave_load(input logic [7:0] b0);
    slv_q.delete();
    slv_bit = 0;
    slv_cur = b0;
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic [7:0] d);
    bit seen;
    seen = 1'b0;
    @(negedge clock);
    spi_cmd  = c;
    spi_out  = d;
    spi_sent = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (spi_st[0]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL busy_rise cmd=%0d got busy=0 want 1", c);
    end
    spi_sent = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (!spi_st[0]) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_idle got busy=1 want 0 within %0d cycles", tag, budget);
    end
  endtask

  task automatic test_reset();
    spi_sent = 1'b1;
    reset_n  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({spi_cs, spi_sclk, spi_mosi} !== 3'b101) begin
      errors++;
      $display("FAIL reset_pins got cs/sclk/mosi=%b want 101", {spi_cs, spi_sclk, spi_mosi});
    end
    checks++;
    if (spi_din !== 8'hFF || spi_st !== 2'b00) begin
      errors++;
      $display("FAIL reset_regs got din=%h st=%b want din=ff st=00", spi_din, spi_st);
    end
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    checks++;
    if (spi_st !== 2'b00 || pulses != 0) begin
      errors++;
      $display("FAIL stale_trigger got st=%b pulses=%0d want st=00 pulses=0", spi_st, pulses);
    end
    spi_sent = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_xfer(input logic [7:0] tx, input logic [7:0] rx, input string tag);
    logic [7:0] got;
    logic       cs_before;
    cs_before = spi_cs;
    clear_mon();
    slave_load(rx);
    send_cmd(CMD_XFER, tx);
    wait_idle(200, tag);
    got = '0;
    for (int i = 0; i < 8 && i < mosi_q.size(); i++) got = {got[6:0], mosi_q[i]};
    checks++;
    if (pulses != 8) begin
      errors++;
      $display("FAIL %s_pulses got %0d want 8", tag, pulses);
    end
    checks++;
    if (got !== tx) begin
      errors++;
      $display("FAIL %s_mosi got %h want %h", tag, got, tx);
    end
    checks++;
    if (hi_cnt != 8 * CLK_DIV || (last_hi - first_hi + 1) != 15 * CLK_DIV) begin
      errors++;
      $display("FAIL %s_timing got high=%0d span=%0d want high=%0d span=%0d", tag, hi_cnt,
               last_hi - first_hi + 1, 8 * CLK_DIV, 15 * CLK_DIV);
    end
    checks++;
    if (spi_din !== rx || spi_st !== 2'b00) begin
      errors++;
      $display("FAIL %s_result got din=%h st=%b want din=%h st=00", tag, spi_din, spi_st, rx);
    end
    checks++;
    if (spi_cs !== cs_before) begin
      errors++;
      $display("FAIL %s_cs got %b want %b", tag, spi_cs, cs_before);
    end
  endtask

  task automatic test_cs();
    clear_mon();
    send_cmd(CMD_CS_LO, 8'h00);
    wait_idle(20, "cs_lo");
    checks++;
    if (spi_cs !== 1'b0 || spi_st !== 2'b00) begin
      errors++;
      $display("FAIL cs_lo got cs=%b st=%b want cs=0 st=00", spi_cs, spi_st);
    end
    send_cmd(CMD_CS_HI, 8'h00);
    wait_idle(20, "cs_hi");
    checks++;
    if (spi_cs !== 1'b1 || pulses != 0) begin
      errors++;
      $display("FAIL cs_hi got cs=%b pulses=%0d want cs=1 pulses=0", spi_cs, pulses);
    end
  endtask

  task automatic test_wait(input string tag);
    int         exp_n;
    logic [7:0] exp_din;
    logic [7:0] b;
    logic       exp_to;
    int         ones;
    exp_n = 0;
    exp_din = 8'hFF;
    for (int n = 1; n <= int'(WAIT_LIMIT); n++) begin
      b = (n - 1 < resp_len) ? resp_tab[n-1] : 8'hFF;
      exp_n = n;
      exp_din = b;
      if (b != 8'hFF) break;
    end
    exp_to = (exp_din == 8'hFF);
    clear_mon();
    slave_load((resp_len > 0) ? resp_tab[0] : 8'hFF);
    for (int i = 1; i < resp_len; i++) slv_q.push_back(resp_tab[i]);
    send_cmd(CMD_WAIT, 8'($urandom));
    wait_idle(int'(WAIT_LIMIT) * 48 + 100, tag);
    ones = 0;
    foreach (mosi_q[i]) if (mosi_q[i] === 1'b1) ones++;
    checks++;
    if (pulses != 8 * exp_n || ones != pulses) begin
      errors++;
      $display("FAIL %s_bytes got pulses=%0d mosi_ones=%0d want %0d", tag, pulses, ones, 8 * exp_n);
    end
    checks++;
    if (spi_st !== {exp_to, 1'b0}) begin
      errors++;
      $display("FAIL %s_status got %b want %b", tag, spi_st, {exp_to, 1'b0});
    end
    checks++;
    if (spi_din !== exp_din) begin
      errors++;
      $display("FAIL %s_din got %h want %h", tag, spi_din, exp_din);
    end
  endtask

  task automatic test_ignore_busy_trigger();
    logic [7:0] rx;
    rx = 8'($urandom);
    clear_mon();
    slave_load(rx);
    send_cmd(CMD_XFER, 8'($urandom));
    repeat (6) @(negedge clock);
    spi_sent = 1'b1;
    repeat (4) @(negedge clock);
    spi_sent = 1'b0;
    repeat (4) @(negedge clock);
    spi_sent = 1'b1;
    wait_idle(200, "ignore");
    repeat (20) @(negedge clock);
    checks++;
    if (pulses != 8 || spi_st[0] !== 1'b0 || spi_din !== rx) begin
      errors++;
      $display("FAIL ignore_trigger got pulses=%0d busy=%b din=%h want 8 0 %h", pulses, spi_st[0],
               spi_din, rx);
    end
    spi_sent = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    bit reached;
    send_cmd(CMD_CS_LO, 8'h00);
    wait_idle(20, "mid_cs");
    clear_mon();
    slave_load(8'hFF);
    send_cmd(CMD_XFER, 8'($urandom));
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clock);
      if (pulses >= 4) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL mid_reach got pulses=%0d want 4", pulses);
    end
    reset_n  = 1'b0;
    spi_sent = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (spi_sclk !== 1'b0 || spi_cs !== 1'b1 || spi_st !== 2'b00 || spi_mosi !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got sclk=%b cs=%b st=%b mosi=%b want 0 1 00 1", spi_sclk, spi_cs,
               spi_st, spi_mosi);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    checks++;
    if (spi_st !== 2'b00) begin
      errors++;
      $display("FAIL mid_stale got st=%b want 00", spi_st);
    end
    spi_sent = 1'b0;
    repeat (3) @(negedge clock);
    test_xfer(8'($urandom), 8'($urandom), "after_reset");
  endtask

  initial begin
    #1200000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    reset_n  = 1'b1;
    spi_sent = 1'b0;
    spi_cmd  = CMD_XFER;
    spi_out  = 8'h00;
    clear_mon();
    slave_load(8'hFF);

    test_reset();
    test_xfer(8'hA5, 8'hFF, "xfer_a5");
    test_cs();
    test_xfer(8'h5A, 8'h3C, "xfer_3c");
    for (int i = 0; i < 4; i++) test_xfer(8'($urandom), 8'($urandom), "xfer_rand");

    resp_len = 0;
    test_wait("wait_timeout");
    test_cs();
    resp_tab[0] = 8'hFF;
    resp_tab[1] = 8'hFF;
    resp_tab[2] = 8'h01;
    resp_len = 3;
    test_wait("wait_third");
    for (int k = 0; k < 2; k++) begin
      resp_len = int'($urandom_range(1, 12));
      for (int i = 0; i < resp_len - 1; i++) resp_tab[i] = 8'hFF;
      resp_tab[resp_len-1] = 8'($urandom_range(0, 254));
      test_wait("wait_rand");
    end

    test_ignore_busy_trigger();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi.md
SPI -- requirements
Module: spi

Interface
REQ-001 Parameter CLK_DIV, default 2: system clocks per SCLK half-period, minimum 1.
REQ-002 Parameter WAIT_LIMIT, default 256: maximum bytes polled by the wait command.
REQ-003 Ports, one clock; reset is synchronous and active-low:
- clock  in  1  system clock, 50 MHz; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- spi_cs  out  1  chip select, active low.
- spi_sclk  out  1  serial clock, idles low.
- spi_miso  in  1  serial data from the slave.
- spi_mosi  out  1  serial data to the slave.
- spi_sent  in  1  command trigger from the CPU; asynchronous, level-toggled.
- spi_cmd  in  2  command code, sampled when the trigger is detected.
- spi_din  out  8  last received byte.
- spi_out  in  8  byte to transmit, sampled when the trigger is detected.
- spi_st  out  2  status: bit1 timeout, bit0 busy.

Function
REQ-004 spi_sent SHALL pass through a 2-flop synchronizer; a command starts on a rising edge of the synchronized signal.
REQ-005 spi_cmd and spi_out SHALL be latched in the edge-detect cycle, and busy (spi_st[0]) SHALL read 1 from the next cycle.
REQ-006 A trigger arriving while busy SHALL be ignored.
REQ-007 cmd 0 (transfer) SHALL shift spi_out MSB first in SPI mode 0:
- MOSI changes while SCLK is low; MISO is sampled on the SCLK rising edge.
- 8 SCLK pulses, each CLK_DIV high and CLK_DIV low.
- Transfer duration is 16*CLK_DIV clocks.
REQ-008 At the end of a transfer, spi_din SHALL take the received byte and busy SHALL clear in the same cycle.
REQ-009 cmd 1 SHALL drive spi_cs low; cmd 2 SHALL drive spi_cs high.
- Both take one cycle of busy, with no SCLK activity.
REQ-010 cmd 3 (wait response) SHALL repeatedly transfer 0xFF until a received byte is not 0xFF, or until WAIT_LIMIT bytes are done.
- spi_din holds the last byte received.
- spi_st[1] SHALL be set if and only if the limit was reached.
REQ-011 spi_st[1] SHALL clear at the start of any new command.
REQ-012 spi_cs SHALL change only under cmd 1 and cmd 2; transfers SHALL NOT touch it.
REQ-013 FSM states:
- IDLE -> LOAD on trigger.
- LOAD -> SHIFT for cmd 0 and cmd 3.
- LOAD -> IDLE for cmd 1 and cmd 2.
- SHIFT -> IDLE or SHIFT at the byte end, per REQ-010.
REQ-014 Between bytes of cmd 3, SCLK SHALL stay low for at least CLK_DIV clocks.
REQ-015 In IDLE, MOSI SHALL hold 1.
REQ-016 The byte counter SHALL be sized for WAIT_LIMIT and SHALL NOT wrap; reaching the limit terminates the command.

Reset
REQ-017 While reset_n is low at a rising edge, the block SHALL load:
- spi_cs=1, spi_sclk=0, spi_mosi=1;
- spi_din=0xFF, spi_st=2'b00;
- FSM to IDLE;
- synchronizer flops to the current spi_sent, so a stale high level does not start a command.
REQ-018 Reset during a transfer SHALL abort it immediately; the next command after reset SHALL start cleanly.

Structure
REQ-019 A shared package SHALL hold:
- command codes CMD_XFER=0, CMD_CS_LO=1, CMD_CS_HI=2, CMD_WAIT=3;
- the FSM state enum;
- status bit indices.
REQ-020 A single sub-module, spi_shifter, SHALL own the clock divider and the 8-bit shift register. The command FSM SHALL stay in spi.

Verification
REQ-021 Reset, then cmd 0 with spi_out=0xA5 and MISO held 1:
- MOSI bits are 1,0,1,0,0,1,0,1 at the SCLK rising edges;
- exactly 8 SCLK pulses over 32 clocks (CLK_DIV=2);
- spi_din=0xFF and busy drops.
REQ-022 cmd 1, then cmd 2 -> spi_cs goes 0, then 1, with no SCLK toggles.
REQ-023 cmd 0 with MISO driven as 0x3C by a slave model -> spi_din=0x3C and spi_st=2'b00.
REQ-024 cmd 3 with MISO held 1 -> 256 bytes of 0xFF, spi_st=2'b10 and spi_din=0xFF. Repeat with the slave answering 0x01 on the third byte -> 3 bytes, spi_st=2'b00 and spi_din=0x01.
REQ-025 Toggle spi_sent again during a busy transfer -> the extra trigger is ignored and only 8 SCLK pulses occur.
REQ-026 Assert reset_n=0 at bit 4 of a transfer -> the next clock gives spi_sclk=0, spi_cs=1 and spi_st=0; a following cmd 0 completes normally.
